// File: rtl/core_pkg.sv
// Shared RV32I core types: LSU operation codes, LSU FSM states and op classifiers.
package core_pkg;

   typedef enum logic [3:0] {
      LSU_NONE_OP = 4'h0,
      LSU_LB      = 4'h1,
      LSU_LH      = 4'h2,
      LSU_LW      = 4'h3,
      LSU_LBU     = 4'h4,
      LSU_LHU     = 4'h5,
      LSU_SB      = 4'h8,
      LSU_SH      = 4'h9,
      LSU_SW      = 4'hA
   } lsu_op_t;

   typedef enum logic [2:0] {
      LSU_IDLE = 3'd0,
      LSU_REQ  = 3'd1,
      LSU_RESP = 3'd2,
      LSU_DONE = 3'd3,
      LSU_ERR  = 3'd4
   } lsu_state_t;

   function automatic logic lsu_is_load(lsu_op_t op);
      return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
             (op == LSU_LBU) || (op == LSU_LHU);
   endfunction

   function automatic logic lsu_is_store(lsu_op_t op);
      return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
   endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Byte-lane steering between the core's low-aligned data and the 32-bit memory bus.
module lsu_data_aligner
   import core_pkg::*;
(
   input  logic [3:0]  st_op,
   input  logic [1:0]  st_off,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   input  logic [3:0]  ld_op,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] rdata_ext
);

   logic [31:0] rd_sh;

   // Loads drive the same enables as stores of their size.
   always_comb begin
      be         = 4'b0000;
      wdata_lane = wdata;
      case (lsu_op_t'(st_op))
         LSU_LB, LSU_LBU, LSU_SB: begin
            be         = 4'b0001 << st_off;
            wdata_lane = {4{wdata[7:0]}};
         end
         LSU_LH, LSU_LHU, LSU_SH: begin
            be         = 4'b0011 << st_off;
            wdata_lane = {2{wdata[15:0]}};
         end
         LSU_LW, LSU_SW: be = 4'hF;
         default: be = 4'b0000;
      endcase
   end

   assign rd_sh = rdata >> {ld_off, 3'b000};

   always_comb begin
      rdata_ext = rdata;
      case (lsu_op_t'(ld_op))
         LSU_LB:  rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
         LSU_LBU: rdata_ext = {24'h0, rd_sh[7:0]};
         LSU_LH:  rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
         LSU_LHU: rdata_ext = {16'h0, rd_sh[15:0]};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one outstanding req/gnt/rvalid access at a time,
// with misalignment detection and a gnt/rvalid timeout.
module load_store_unit
   import core_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [3:0]      lsu_op_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misalign_o,
   output logic            bus_err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [3:0]      mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

   lsu_state_t      state_q;
   lsu_op_t         op, op_q;
   logic [1:0]      off_q;
   logic            err_bus_q;
   logic [CW-1:0]   cnt_q;
   logic            access, misal, timeout;
   logic [3:0]      be;
   logic [31:0]     wdata_lane, rdata_ext;

   assign op      = lsu_op_t'(lsu_op_i);
   assign access  = valid_i && (lsu_is_load(op) || lsu_is_store(op));
   assign misal   = (((op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH)) && addr_i[0]) ||
                    (((op == LSU_LW) || (op == LSU_SW)) && (addr_i[1:0] != 2'b00));
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   lsu_data_aligner u_aligner (
      .st_op      (lsu_op_i),
      .st_off     (addr_i[1:0]),
      .wdata      (wdata_i),
      .be         (be),
      .wdata_lane (wdata_lane),
      .ld_op      (op_q),
      .ld_off     (off_q),
      .rdata      (mem_rdata_i),
      .rdata_ext  (rdata_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LSU_IDLE;
         op_q        <= LSU_NONE_OP;
         off_q       <= 2'b00;
         err_bus_q   <= 1'b0;
         cnt_q       <= '0;
         rdata_o     <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= '0;
      end else begin
         case (state_q)
            LSU_IDLE: if (access) begin
               op_q  <= op;
               off_q <= addr_i[1:0];
               cnt_q <= '0;
               if (misal) begin
                  err_bus_q <= 1'b0;
                  state_q   <= LSU_ERR;
               end else begin
                  // Bus fields are frozen here so they stay stable until gnt.
                  mem_we_o    <= lsu_is_store(op);
                  mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                  mem_be_o    <= be;
                  mem_wdata_o <= wdata_lane;
                  state_q     <= LSU_REQ;
               end
            end
            LSU_REQ: begin
               if (mem_gnt_i) begin
                  cnt_q   <= '0;
                  state_q <= mem_we_o ? LSU_DONE : LSU_RESP;
               end else if (timeout) begin
                  err_bus_q <= 1'b1;
                  state_q   <= LSU_ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            LSU_RESP: begin
               if (mem_rvalid_i) begin
                  rdata_o <= rdata_ext;
                  state_q <= LSU_DONE;
               end else if (timeout) begin
                  err_bus_q <= 1'b1;
                  state_q   <= LSU_ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

   assign mem_req_o  = (state_q == LSU_REQ);
   assign done_o     = (state_q == LSU_DONE) || (state_q == LSU_ERR);
   assign misalign_o = (state_q == LSU_ERR) && !err_bus_q;
   assign bus_err_o  = (state_q == LSU_ERR) && err_bus_q;
   assign stall_o    = access && !done_o;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checks of load_store_unit against a byte-level access model.
module tb_load_store_unit;
   import core_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [3:0]  lsu_op_i = 4'h0;
   logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;

   logic        stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        stall_t, done_t, misalign_t, bus_err_t, req_t, we_t;
   logic [31:0] rdata_t, addr_t, wdata_t;
   logic [3:0]  be_t;

   int checks = 0, failures = 0;
   logic [31:0] last_load = '0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .lsu_op_i(lsu_op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i));

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst(rst), .valid_i(valid_i), .lsu_op_i(lsu_op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .stall_o(stall_t), .done_o(done_t), .rdata_o(rdata_t),
      .misalign_o(misalign_t), .bus_err_o(bus_err_t), .mem_req_o(req_t),
      .mem_we_o(we_t), .mem_addr_o(addr_t), .mem_be_o(be_t),
      .mem_wdata_o(wdata_t), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i));

   // Reference model: an access is a run of `size` bytes starting at the byte offset.
   function automatic int op_size(logic [3:0] op);
      case (op)
         4'h1, 4'h4, 4'h8: return 1;
         4'h2, 4'h5, 4'h9: return 2;
         4'h3, 4'hA:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit op_load(logic [3:0] op);
      return (op >= 4'h1) && (op <= 4'h5);
   endfunction

   function automatic bit op_signed(logic [3:0] op);
      return (op == 4'h1) || (op == 4'h2);
   endfunction

   function automatic logic [3:0] model_be(int size, int off);
      logic [3:0] b = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + size) b[i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] model_wdata(int size, logic [31:0] wd);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(logic [3:0] op, int off, logic [31:0] rd);
      longint v = 0;
      int size = op_size(op);
      for (int k = 0; k < size; k++) v += longint'(rd[8*(off+k) +: 8]) << (8*k);
      if (op_signed(op) && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
      return 32'(v);
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_load = '0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = $urandom_range(0, 1);
      @(negedge clk);
      checks++; if (done_o !== 1'b0 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
         failures++; $display("FAIL idle: done=%b req=%b stall=%b want 0 0 0", done_o, mem_req_o, stall_o); end
   endtask

   // One access: gd cycles without gnt before the gnt cycle, rd cycles without rvalid.
   task automatic do_access(logic [3:0] op, logic [31:0] addr, logic [31:0] wd,
                            int gd, int rd, logic [31:0] rdat);
      int size = op_size(op);
      int off = int'(addr[1:0]);
      @(posedge clk); #1;
      valid_i = 1'b1; lsu_op_i = op; addr_i = addr; wdata_i = wd;
      mem_gnt_i = 1'b0; mem_rvalid_i = $urandom_range(0, 1); mem_rdata_i = $urandom;
      @(negedge clk);
      if (size == 0) begin
         checks++; if (stall_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++; $display("FAIL no_access op=%h: stall=%b done=%b req=%b want 0 0 0", op, stall_o, done_o, mem_req_o); end
         return;
      end
      checks++; if (stall_o !== 1'b1 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
         failures++; $display("FAIL idle_sample op=%h: stall=%b done=%b req=%b want 1 0 0", op, stall_o, done_o, mem_req_o); end
      if (off % size != 0) begin
         @(posedge clk); #1; mem_rvalid_i = 1'b0;
         @(negedge clk);
         checks++; if ({done_o, misalign_o, bus_err_o, mem_req_o, stall_o} !== 5'b11000 || rdata_o !== last_load) begin
            failures++; $display("FAIL misalign op=%h addr=%h: done/mis/berr/req/stall=%b rdata=%h want 11000 %h",
                                 op, addr, {done_o, misalign_o, bus_err_o, mem_req_o, stall_o}, rdata_o, last_load); end
         return;
      end
      for (int g = 0; g <= gd; g++) begin
         @(posedge clk); #1;
         mem_gnt_i = (g == gd); mem_rvalid_i = $urandom_range(0, 1); mem_rdata_i = $urandom;
         @(negedge clk);
         checks++; if (mem_req_o !== 1'b1 || stall_o !== 1'b1 || done_o !== 1'b0 ||
                       mem_we_o !== !op_load(op) || mem_addr_o !== {addr[31:2], 2'b00} ||
                       mem_be_o !== model_be(size, off)) begin
            failures++; $display("FAIL req op=%h addr=%h: req=%b stall=%b done=%b we=%b maddr=%h be=%b want 1 1 0 %b %h %b",
               op, addr, mem_req_o, stall_o, done_o, mem_we_o, mem_addr_o, mem_be_o,
               !op_load(op), {addr[31:2], 2'b00}, model_be(size, off)); end
         if (!op_load(op)) begin
            checks++; if (mem_wdata_o !== model_wdata(size, wd)) begin
               failures++; $display("FAIL wdata op=%h: got %h want %h", op, mem_wdata_o, model_wdata(size, wd)); end
         end
      end
      if (op_load(op)) begin
         for (int r = 0; r <= rd; r++) begin
            @(posedge clk); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = (r == rd); mem_rdata_i = (r == rd) ? rdat : $urandom;
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || done_o !== 1'b0) begin
               failures++; $display("FAIL resp op=%h: req=%b stall=%b done=%b want 0 1 0", op, mem_req_o, stall_o, done_o); end
         end
         last_load = model_load(op, off, rdat);
      end
      @(posedge clk); #1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      @(negedge clk);
      checks++; if ({done_o, misalign_o, bus_err_o, mem_req_o, stall_o} !== 5'b10000 || rdata_o !== last_load) begin
         failures++; $display("FAIL done op=%h addr=%h: done/mis/berr/req/stall=%b rdata=%h want 10000 %h",
                              op, addr, {done_o, misalign_o, bus_err_o, mem_req_o, stall_o}, rdata_o, last_load); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o} !== 6'b0 ||
                    rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0 ||
                    {done_t, req_t, bus_err_t} !== 3'b0) begin
         failures++; $display("FAIL reset: flags=%b rdata=%h addr=%h be=%b wdata=%h want all 0",
            {stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o}, rdata_o, mem_addr_o, mem_be_o, mem_wdata_o); end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      do_access(4'(LSU_LB), 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234);
      checks++; if (rdata_o !== 32'hFFFF_FF80) begin
         failures++; $display("FAIL lb_0x103: rdata=%h want ffffff80", rdata_o); end
      idle_cycle();
      do_access(4'(LSU_SH), 32'h0000_0022, 32'h0000_ABCD, 0, 0, 32'h0);
      idle_cycle();
      do_access(4'(LSU_LW), 32'h0000_0042, 32'h0, 0, 0, 32'h0);
      idle_cycle();
      do_access(4'(LSU_LHU), 32'h0000_0002, 32'h0, 5, 0, 32'h8001_0000);
      checks++; if (rdata_o !== 32'h0000_8001) begin
         failures++; $display("FAIL lhu_wait: rdata=%h want 00008001", rdata_o); end
      idle_cycle();
   endtask

   task automatic test_timeout();
      apply_reset();
      @(posedge clk); #1;
      valid_i = 1'b1; lsu_op_i = 4'(LSU_SW); addr_i = 32'h10; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (req_t !== 1'b1 || done_t !== 1'b0 || stall_t !== 1'b1) begin
            failures++; $display("FAIL to_req_wait c%0d: req=%b done=%b stall=%b want 1 0 1", c, req_t, done_t, stall_t); end
      end
      @(posedge clk); @(negedge clk);
      checks++; if ({req_t, done_t, bus_err_t, misalign_t, stall_t} !== 5'b01100) begin
         failures++; $display("FAIL to_req: req/done/berr/mis/stall=%b want 01100", {req_t, done_t, bus_err_t, misalign_t, stall_t}); end
      @(posedge clk); #1; valid_i = 1'b0;
      @(negedge clk);
      // Load with gnt but no rvalid: four RESP cycles, then the timeout error.
      @(posedge clk); #1; valid_i = 1'b1; lsu_op_i = 4'(LSU_LW); addr_i = 32'h20;
      @(posedge clk); #1; mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++; if (req_t !== 1'b0 || done_t !== 1'b0) begin
            failures++; $display("FAIL to_resp_wait c%0d: req=%b done=%b want 0 0", c, req_t, done_t); end
         @(posedge clk);
      end
      @(negedge clk);
      checks++; if ({done_t, bus_err_t, misalign_t} !== 3'b110) begin
         failures++; $display("FAIL to_resp: done/berr/mis=%b want 110", {done_t, bus_err_t, misalign_t}); end
      apply_reset();
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1; valid_i = 1'b1; lsu_op_i = 4'(LSU_LW); addr_i = 32'h40; mem_rvalid_i = 1'b0;
      @(posedge clk); #1; mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      @(negedge clk);
      checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
         failures++; $display("FAIL mid_pre: req=%b stall=%b want 0 1", mem_req_o, stall_o); end
      rst = 1'b1; valid_i = 1'b0;
      #1;
      checks++; if ({stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o} !== 6'b0 ||
                    rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0) begin
         failures++; $display("FAIL mid_reset: flags=%b rdata=%h addr=%h be=%b want all 0",
            {stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o}, rdata_o, mem_addr_o, mem_be_o); end
      @(negedge clk); rst = 1'b0; last_load = '0;
      @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (done_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0) begin
            failures++; $display("FAIL stray_rvalid c%0d: done=%b req=%b rdata=%h want 0 0 0", c, done_o, mem_req_o, rdata_o); end
         @(posedge clk); #1; mem_rvalid_i = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      do_access(4'(LSU_SW), 32'h0000_1000, 32'h1234_5678, 0, 0, 32'h0);
      do_access(4'(LSU_LH), 32'h0000_1002, 32'h0, 0, 1, 32'h9ABC_0000);
      do_access(4'(LSU_SB), 32'h0000_1001, 32'h0000_00A5, 1, 0, 32'h0);
      do_access(4'(LSU_LBU), 32'h0000_1001, 32'h0, 0, 0, 32'h0000_F200);
      do_access(4'(LSU_SH), 32'h0000_1003, 32'h0, 0, 0, 32'h0);
      do_access(4'(LSU_LW), 32'h0000_1004, 32'h0, 2, 2, 32'hCAFE_F00D);
      idle_cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         logic [3:0] op = 4'($urandom_range(0, 15));
         do_access(op, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
